// File: rtl/fetch_queue_pkg.sv
// Shared fetch-path definitions: default widths, NOP encoding and the
// packed fetch-entry layout reused by the fetch queue and the decode stage.
package fetch_queue_pkg;

  localparam int unsigned FQ_ADDR_WIDTH           = 16;
  localparam int unsigned FQ_INST_WIDTH           = 32;
  localparam int unsigned FQ_INSTRUCTION_ID_WIDTH = 16;

  // addi x0, x0, 0
  localparam logic [31:0] FQ_NOP_INSTRUCTION = 32'h0000_0013;

  // Default-width entry, LSB first: pc, id, instruction, branch_taken, target.
  typedef struct packed {
    logic [FQ_ADDR_WIDTH-1:0]           branch_taken_address;
    logic                               branch_taken;
    logic [FQ_INST_WIDTH-1:0]           instruction;
    logic [FQ_INSTRUCTION_ID_WIDTH-1:0] id;
    logic [FQ_ADDR_WIDTH-1:0]           pc;
  } fq_entry_t;

  localparam int unsigned FQ_ENTRY_WIDTH = $bits(fq_entry_t);

  // Layout helpers for non-default widths; same field order as fq_entry_t.
  function automatic int unsigned fq_entry_width(input int unsigned aw,
                                                 input int unsigned iw,
                                                 input int unsigned idw);
    return 2 * aw + iw + idw + 1;
  endfunction

  function automatic int unsigned fq_pc_lsb();
    return 0;
  endfunction

  function automatic int unsigned fq_id_lsb(input int unsigned aw);
    return aw;
  endfunction

  function automatic int unsigned fq_inst_lsb(input int unsigned aw,
                                              input int unsigned idw);
    return aw + idw;
  endfunction

  function automatic int unsigned fq_bt_bit(input int unsigned aw,
                                            input int unsigned iw,
                                            input int unsigned idw);
    return aw + idw + iw;
  endfunction

  function automatic int unsigned fq_bta_lsb(input int unsigned aw,
                                             input int unsigned iw,
                                             input int unsigned idw);
    return aw + idw + iw + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_ram.sv
// DEPTH x WIDTH register file, two write ports and two combinational reads.
// The two write addresses are always distinct in use; port 1 wins a tie.
module fetch_queue_ram
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = FQ_ENTRY_WIDTH
) (
  input  logic                     clk,
  input  logic                     we0_i,
  input  logic [$clog2(DEPTH)-1:0] waddr0_i,
  input  logic [WIDTH-1:0]         wdata0_i,
  input  logic                     we1_i,
  input  logic [$clog2(DEPTH)-1:0] waddr1_i,
  input  logic [WIDTH-1:0]         wdata1_i,
  input  logic [$clog2(DEPTH)-1:0] raddr0_i,
  output logic [WIDTH-1:0]         rdata0_o,
  input  logic [$clog2(DEPTH)-1:0] raddr1_i,
  output logic [WIDTH-1:0]         rdata1_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Entry storage; no reset needed, validity is tracked by the queue count.
  always_ff @(posedge clk) begin
    if (we0_i) mem_q[waddr0_i] <= wdata0_i;
    if (we1_i) mem_q[waddr1_i] <= wdata1_i;
  end

  // Asynchronous read of the head and head+1 slots.
  always_comb begin
    rdata0_o = mem_q[raddr0_i];
    rdata1_o = mem_q[raddr1_i];
  end

endmodule

// File: rtl/fetch_queue.sv
// Dual-issue instruction buffer between fetch and dispatch. Up to two
// entries enter and two leave per cycle; status outputs depend only on the
// registered count so fetch sees no combinational path from push/pop.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = FQ_ADDR_WIDTH,
  parameter int unsigned INST_WIDTH = FQ_INST_WIDTH,
  parameter int unsigned ID_WIDTH   = FQ_INSTRUCTION_ID_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      push0,
  input  logic                      push1,
  input  logic [ADDR_WIDTH-1:0]     pc0,
  input  logic [ADDR_WIDTH-1:0]     pc1,
  input  logic [ID_WIDTH-1:0]       id0,
  input  logic [ID_WIDTH-1:0]       id1,
  input  logic [INST_WIDTH-1:0]     instruction0,
  input  logic [INST_WIDTH-1:0]     instruction1,
  input  logic                      branch_taken0,
  input  logic                      branch_taken1,
  input  logic [ADDR_WIDTH-1:0]     branch_taken_address0,
  input  logic [ADDR_WIDTH-1:0]     branch_taken_address1,
  input  logic                      pop0,
  input  logic                      pop1,
  output logic [$clog2(DEPTH):0]    free,
  output logic                      stall,
  output logic                      valid0,
  output logic                      valid1,
  output logic [ADDR_WIDTH-1:0]     out_pc0,
  output logic [ADDR_WIDTH-1:0]     out_pc1,
  output logic [ID_WIDTH-1:0]       out_id0,
  output logic [ID_WIDTH-1:0]       out_id1,
  output logic [INST_WIDTH-1:0]     out_instruction0,
  output logic [INST_WIDTH-1:0]     out_instruction1,
  output logic                      out_branch_taken0,
  output logic                      out_branch_taken1,
  output logic [ADDR_WIDTH-1:0]     out_branch_taken_address0,
  output logic [ADDR_WIDTH-1:0]     out_branch_taken_address1
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned EW  = fq_entry_width(ADDR_WIDTH, INST_WIDTH, ID_WIDTH);
  localparam int unsigned PCL = fq_pc_lsb();
  localparam int unsigned IDL = fq_id_lsb(ADDR_WIDTH);
  localparam int unsigned INL = fq_inst_lsb(ADDR_WIDTH, ID_WIDTH);
  localparam int unsigned BTB = fq_bt_bit(ADDR_WIDTH, INST_WIDTH, ID_WIDTH);
  localparam int unsigned BAL = fq_bta_lsb(ADDR_WIDTH, INST_WIDTH, ID_WIDTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] TWO_C   = CW'(2);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [CW-1:0] free_c;
  logic          acc0, acc1;
  logic          pa0, pa1;

  logic          we0, we1;
  logic [PW-1:0] waddr0, waddr1;
  logic [EW-1:0] wentry0, wentry1, wdata0;
  logic [EW-1:0] rentry0, rentry1;

  // Status flags derived solely from the registered occupancy.
  always_comb begin
    free_c = DEPTH_C - count_q;
    free   = free_c;
    stall  = (count_q == DEPTH_C);
    valid0 = (count_q >= ONE_C);
    valid1 = (count_q >= TWO_C);
  end

  // Push/pop acceptance against the occupancy at the start of the cycle.
  always_comb begin
    acc0 = push0 && (free_c >= ONE_C);
    acc1 = push1 && (free_c >= (push0 ? TWO_C : ONE_C));
    pa0  = pop0 && (count_q >= ONE_C);
    pa1  = pop0 && pop1 && (count_q >= TWO_C);
  end

  // Pack fetch slots into the shared entry layout.
  always_comb begin
    wentry0 = {branch_taken_address0, branch_taken0, instruction0, id0, pc0};
    wentry1 = {branch_taken_address1, branch_taken1, instruction1, id1, pc1};
  end

  // Write ports: a lone slot-1 push is compacted onto wr_ptr via port 0.
  always_comb begin
    we0    = (acc0 || acc1) && !reset && !flush;
    we1    = acc0 && acc1 && !reset && !flush;
    waddr0 = wr_ptr_q;
    waddr1 = wr_ptr_q + PW'(1);
    wdata0 = acc0 ? wentry0 : wentry1;
  end

  // Next pointer and occupancy; flush discards everything including this
  // cycle's pushes and pops.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pa0) + PW'(pa1);
    wr_ptr_d = wr_ptr_q + PW'(acc0) + PW'(acc1);
    count_d  = count_q + CW'(acc0) + CW'(acc1) - CW'(pa0) - CW'(pa1);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Pointer and occupancy registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  fetch_queue_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk      (clk),
    .we0_i    (we0),
    .waddr0_i (waddr0),
    .wdata0_i (wdata0),
    .we1_i    (we1),
    .waddr1_i (waddr1),
    .wdata1_i (wentry1),
    .raddr0_i (rd_ptr_q),
    .rdata0_o (rentry0),
    .raddr1_i (rd_ptr_q + PW'(1)),
    .rdata1_o (rentry1)
  );

  // Head / head+1 fields, forced to zero when the slot is not valid.
  always_comb begin
    out_pc0                   = '0;
    out_id0                   = '0;
    out_instruction0          = '0;
    out_branch_taken0         = 1'b0;
    out_branch_taken_address0 = '0;
    out_pc1                   = '0;
    out_id1                   = '0;
    out_instruction1          = '0;
    out_branch_taken1         = 1'b0;
    out_branch_taken_address1 = '0;
    if (valid0) begin
      out_pc0                   = rentry0[PCL +: ADDR_WIDTH];
      out_id0                   = rentry0[IDL +: ID_WIDTH];
      out_instruction0          = rentry0[INL +: INST_WIDTH];
      out_branch_taken0         = rentry0[BTB];
      out_branch_taken_address0 = rentry0[BAL +: ADDR_WIDTH];
    end
    if (valid1) begin
      out_pc1                   = rentry1[PCL +: ADDR_WIDTH];
      out_id1                   = rentry1[IDL +: ID_WIDTH];
      out_instruction1          = rentry1[INL +: INST_WIDTH];
      out_branch_taken1         = rentry1[BTB];
      out_branch_taken_address1 = rentry1[BAL +: ADDR_WIDTH];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, hand-written
// wrap sequence, and randomized traffic against a queue-based reference.
module tb_fetch_queue;

  localparam int DEPTH = 8;
  localparam int AW    = 16;
  localparam int IW    = 32;
  localparam int DW    = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b0, flush = 1'b0;
  logic          push0 = 1'b0, push1 = 1'b0, pop0 = 1'b0, pop1 = 1'b0;
  logic [AW-1:0] pc0 = '0, pc1 = '0;
  logic [DW-1:0] id0 = '0, id1 = '0;
  logic [IW-1:0] instruction0 = '0, instruction1 = '0;
  logic          branch_taken0 = 1'b0, branch_taken1 = 1'b0;
  logic [AW-1:0] branch_taken_address0 = '0, branch_taken_address1 = '0;

  logic [3:0]    free;
  logic          stall, valid0, valid1;
  logic [AW-1:0] out_pc0, out_pc1;
  logic [DW-1:0] out_id0, out_id1;
  logic [IW-1:0] out_instruction0, out_instruction1;
  logic          out_branch_taken0, out_branch_taken1;
  logic [AW-1:0] out_branch_taken_address0, out_branch_taken_address1;

  fetch_queue #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .INST_WIDTH (IW),
    .ID_WIDTH   (DW)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .flush                     (flush),
    .push0                     (push0),
    .push1                     (push1),
    .pc0                       (pc0),
    .pc1                       (pc1),
    .id0                       (id0),
    .id1                       (id1),
    .instruction0              (instruction0),
    .instruction1              (instruction1),
    .branch_taken0             (branch_taken0),
    .branch_taken1             (branch_taken1),
    .branch_taken_address0     (branch_taken_address0),
    .branch_taken_address1     (branch_taken_address1),
    .pop0                      (pop0),
    .pop1                      (pop1),
    .free                      (free),
    .stall                     (stall),
    .valid0                    (valid0),
    .valid1                    (valid1),
    .out_pc0                   (out_pc0),
    .out_pc1                   (out_pc1),
    .out_id0                   (out_id0),
    .out_id1                   (out_id1),
    .out_instruction0          (out_instruction0),
    .out_instruction1          (out_instruction1),
    .out_branch_taken0         (out_branch_taken0),
    .out_branch_taken1         (out_branch_taken1),
    .out_branch_taken_address0 (out_branch_taken_address0),
    .out_branch_taken_address1 (out_branch_taken_address1)
  );

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] id;
    logic [IW-1:0] ins;
    logic          bt;
    logic [AW-1:0] tg;
  } ent_t;

  typedef struct {
    logic          rst, fl, p0, p1, q0, q1;
    logic [AW-1:0] pc0, pc1;
    logic          bt0;
    logic [AW-1:0] tg0;
    logic [3:0]    e_free;
    logic          e_v0, e_v1;
    logic [AW-1:0] e_pc0, e_pc1;
    logic          e_bt0;
    logic [AW-1:0] e_tg0;
  } vec_t;

  ent_t mq[$];
  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic ent_t zero_ent();
    ent_t z;
    z.pc = '0; z.id = '0; z.ins = '0; z.bt = 1'b0; z.tg = '0;
    return z;
  endfunction

  // Reference: FIFO of entries; acceptance computed from pre-cycle occupancy.
  task automatic model_cycle();
    int   sz, f, np;
    bit   a0, a1;
    ent_t e0, e1;
    e0.pc = pc0; e0.id = id0; e0.ins = instruction0; e0.bt = branch_taken0; e0.tg = branch_taken_address0;
    e1.pc = pc1; e1.id = id1; e1.ins = instruction1; e1.bt = branch_taken1; e1.tg = branch_taken_address1;
    if (reset || flush) begin
      mq.delete();
    end else begin
      sz = mq.size();
      f  = DEPTH - sz;
      a0 = push0 && (f >= 1);
      a1 = push1 && (f >= (push0 ? 2 : 1));
      np = 0;
      if (pop0 && sz >= 1) np = (pop1 && sz >= 2) ? 2 : 1;
      repeat (np) void'(mq.pop_front());
      if (a0) mq.push_back(e0);
      if (a1) mq.push_back(e1);
    end
  endtask

  task automatic check_model(input string tag);
    int   sz;
    ent_t h0, h1;
    sz = mq.size();
    h0 = (sz >= 1) ? mq[0] : zero_ent();
    h1 = (sz >= 2) ? mq[1] : zero_ent();
    chk({tag, ".free"},   free,   64'(DEPTH - sz));
    chk({tag, ".stall"},  stall,  64'(sz == DEPTH));
    chk({tag, ".valid0"}, valid0, 64'(sz >= 1));
    chk({tag, ".valid1"}, valid1, 64'(sz >= 2));
    chk({tag, ".pc0"},    out_pc0, h0.pc);
    chk({tag, ".id0"},    out_id0, h0.id);
    chk({tag, ".ins0"},   out_instruction0, h0.ins);
    chk({tag, ".bt0"},    out_branch_taken0, h0.bt);
    chk({tag, ".tg0"},    out_branch_taken_address0, h0.tg);
    chk({tag, ".pc1"},    out_pc1, h1.pc);
    chk({tag, ".id1"},    out_id1, h1.id);
    chk({tag, ".ins1"},   out_instruction1, h1.ins);
    chk({tag, ".bt1"},    out_branch_taken1, h1.bt);
    chk({tag, ".tg1"},    out_branch_taken_address1, h1.tg);
  endtask

  // One clock: update reference with current inputs, then compare after edge.
  task automatic step(input string tag);
    model_cycle();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic drive(input logic rst, input logic fl, input logic p0, input logic p1,
                       input logic q0, input logic q1, input logic [AW-1:0] a0,
                       input logic [AW-1:0] a1, input logic bt0, input logic [AW-1:0] tg0);
    reset = rst; flush = fl; push0 = p0; push1 = p1; pop0 = q0; pop1 = q1;
    pc0 = a0; pc1 = a1;
    id0 = a0 + 16'h1000; id1 = a1 + 16'h1000;
    instruction0 = {16'hC0DE, a0}; instruction1 = {16'hC0DE, a1};
    branch_taken0 = bt0; branch_taken_address0 = tg0;
    branch_taken1 = 1'b0; branch_taken_address1 = '0;
  endtask

  function automatic vec_t mk(input logic rst, input logic fl, input logic p0, input logic p1,
                              input logic q0, input logic q1, input logic [AW-1:0] a0,
                              input logic [AW-1:0] a1, input logic bt0, input logic [AW-1:0] tg0,
                              input logic [3:0] ef, input logic ev0, input logic ev1,
                              input logic [AW-1:0] ep0, input logic [AW-1:0] ep1,
                              input logic ebt, input logic [AW-1:0] etg);
    vec_t v;
    v.rst = rst; v.fl = fl; v.p0 = p0; v.p1 = p1; v.q0 = q0; v.q1 = q1;
    v.pc0 = a0; v.pc1 = a1; v.bt0 = bt0; v.tg0 = tg0;
    v.e_free = ef; v.e_v0 = ev0; v.e_v1 = ev1; v.e_pc0 = ep0; v.e_pc1 = ep1;
    v.e_bt0 = ebt; v.e_tg0 = etg;
    return v;
  endfunction

  initial begin
    //                rst fl p0 p1 q0 q1  pc0    pc1    bt tg      free v0 v1 epc0   epc1   ebt etg
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 16'h00, 16'h00, 0, 16'h00, 8, 0, 0, 16'h00, 16'h00, 0, 16'h00)); // reset
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 16'h00, 16'h01, 0, 16'h00, 6, 1, 1, 16'h00, 16'h01, 0, 16'h00)); // first pair
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 16'h02, 16'h03, 0, 16'h00, 4, 1, 1, 16'h00, 16'h01, 0, 16'h00));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 16'h04, 16'h05, 0, 16'h00, 2, 1, 1, 16'h00, 16'h01, 0, 16'h00));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 16'h06, 16'h07, 0, 16'h00, 0, 1, 1, 16'h00, 16'h01, 0, 16'h00)); // full
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 16'h08, 16'h09, 0, 16'h00, 0, 1, 1, 16'h00, 16'h01, 0, 16'h00)); // dropped
    tbl.push_back(mk(0, 0, 1, 1, 1, 1, 16'h0A, 16'h0B, 0, 16'h00, 2, 1, 1, 16'h02, 16'h03, 0, 16'h00)); // pop at full, push blocked
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 16'h00, 16'h00, 0, 16'h00, 3, 1, 1, 16'h03, 16'h04, 0, 16'h00));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 16'h00, 16'h20, 0, 16'h00, 2, 1, 1, 16'h03, 16'h04, 0, 16'h00)); // lone push1
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 16'h21, 16'h00, 0, 16'h00, 1, 1, 1, 16'h03, 16'h04, 0, 16'h00));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 16'h22, 16'h23, 0, 16'h00, 0, 1, 1, 16'h03, 16'h04, 0, 16'h00)); // free==1
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 16'h00, 16'h00, 0, 16'h00, 2, 1, 1, 16'h05, 16'h06, 0, 16'h00));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 16'h00, 16'h00, 0, 16'h00, 4, 1, 1, 16'h07, 16'h20, 0, 16'h00));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 16'h00, 16'h00, 0, 16'h00, 6, 1, 1, 16'h21, 16'h22, 0, 16'h00));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 16'h30, 16'h00, 0, 16'h00, 5, 1, 1, 16'h21, 16'h22, 0, 16'h00));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 16'h00, 16'h00, 0, 16'h00, 5, 1, 1, 16'h21, 16'h22, 0, 16'h00)); // pop1 alone
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 16'h00, 16'h00, 0, 16'h00, 7, 1, 0, 16'h30, 16'h00, 0, 16'h00));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 16'h00, 16'h00, 0, 16'h00, 8, 0, 0, 16'h00, 16'h00, 0, 16'h00)); // dual pop, count 1
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 16'h50, 16'h00, 1, 16'h40, 7, 1, 0, 16'h50, 16'h00, 1, 16'h40)); // branch entry
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 16'h00, 16'h00, 0, 16'h00, 8, 0, 0, 16'h00, 16'h00, 0, 16'h00));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 16'h60, 16'h61, 0, 16'h00, 6, 1, 1, 16'h60, 16'h61, 0, 16'h00));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 16'h62, 16'h63, 0, 16'h00, 4, 1, 1, 16'h60, 16'h61, 0, 16'h00));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 16'h64, 16'h00, 0, 16'h00, 3, 1, 1, 16'h60, 16'h61, 0, 16'h00));
    tbl.push_back(mk(0, 1, 1, 0, 1, 0, 16'h65, 16'h00, 0, 16'h00, 8, 0, 0, 16'h00, 16'h00, 0, 16'h00)); // flush
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 16'h66, 16'h00, 0, 16'h00, 7, 1, 0, 16'h66, 16'h00, 0, 16'h00));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 16'h00, 16'h00, 0, 16'h00, 8, 0, 0, 16'h00, 16'h00, 0, 16'h00));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 16'h70, 16'h71, 0, 16'h00, 6, 1, 1, 16'h70, 16'h71, 0, 16'h00));
    tbl.push_back(mk(1, 0, 1, 1, 0, 0, 16'h72, 16'h73, 0, 16'h00, 8, 0, 0, 16'h00, 16'h00, 0, 16'h00)); // reset wins

    // Directed table.
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].fl, tbl[i].p0, tbl[i].p1, tbl[i].q0, tbl[i].q1,
            tbl[i].pc0, tbl[i].pc1, tbl[i].bt0, tbl[i].tg0);
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_free", i),  free,   tbl[i].e_free);
      chk($sformatf("vec%0d.tbl_stall", i), stall,  64'(tbl[i].e_free == 4'd0));
      chk($sformatf("vec%0d.tbl_v0", i),    valid0, tbl[i].e_v0);
      chk($sformatf("vec%0d.tbl_v1", i),    valid1, tbl[i].e_v1);
      chk($sformatf("vec%0d.tbl_pc0", i),   out_pc0, tbl[i].e_pc0);
      chk($sformatf("vec%0d.tbl_pc1", i),   out_pc1, tbl[i].e_pc1);
      chk($sformatf("vec%0d.tbl_bt0", i),   out_branch_taken0, tbl[i].e_bt0);
      chk($sformatf("vec%0d.tbl_tg0", i),   out_branch_taken_address0, tbl[i].e_tg0);
    end

    // Steady-state dual push + dual pop, IDs 1..24, pointers wrap three times.
    drive(1, 0, 0, 0, 0, 0, '0, '0, 0, '0);
    step("wrap_rst");
    for (int k = 0; k < 12; k++) begin
      drive(0, 0, 1, 1, 1, 1, 16'(16'h200 + 2 * k), 16'(16'h201 + 2 * k), 0, '0);
      id0 = 16'(2 * k + 1);
      id1 = 16'(2 * k + 2);
      if (k > 0) begin
        chk($sformatf("wrap%0d.id0", k), out_id0, 64'(2 * k - 1));
        chk($sformatf("wrap%0d.id1", k), out_id1, 64'(2 * k));
      end
      step($sformatf("wrap%0d", k));
      chk($sformatf("wrap%0d.free", k), free, 64'(6));
    end
    drive(0, 0, 0, 0, 1, 1, '0, '0, 0, '0);
    chk("wrap_tail.id0", out_id0, 64'(23));
    chk("wrap_tail.id1", out_id1, 64'(24));
    step("wrap_tail");
    chk("wrap_tail.free", free, 64'(8));

    // Randomized traffic, alternating fill-biased and drain-biased phases.
    for (int c = 0; c < 3000; c++) begin
      int pb, qb;
      pb = ((c / 150) % 2 == 0) ? 8 : 3;
      qb = ((c / 150) % 2 == 0) ? 3 : 8;
      reset = ($urandom_range(199) == 0);
      flush = ($urandom_range(79) == 0);
      push0 = ($urandom_range(9) < pb);
      push1 = ($urandom_range(9) < pb);
      pop0  = ($urandom_range(9) < qb);
      pop1  = ($urandom_range(9) < qb);
      pc0 = 16'($urandom); pc1 = 16'($urandom);
      id0 = 16'($urandom); id1 = 16'($urandom);
      instruction0 = $urandom; instruction1 = $urandom;
      branch_taken0 = 1'($urandom); branch_taken1 = 1'($urandom);
      branch_taken_address0 = 16'($urandom); branch_taken_address1 = 16'($urandom);
      step($sformatf("rnd%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Dual-issue instruction buffer between the program counter (fetch) and decode/dispatch.
- Accepts up to 2 fetched instructions per cycle, each with PC, instruction ID and branch-prediction tag.
- Presents the 2 oldest entries to dispatch, which pops up to 2 per cycle.
- Generates the `free`/`stall` back-pressure that throttles fetch, and discards all contents on a mispredict flush.

Parameters:
DEPTH, 8, number of entries; power of 2, >= 4
ADDR_WIDTH, 16, PC / branch target width
INST_WIDTH, 32, instruction word width
ID_WIDTH, 16, instruction ID width

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  mispredict: discard all entries
push0 / push1  input  1 each  write fetch slot 0 / slot 1
pc0 / pc1  input  ADDR_WIDTH each  PC of slot
id0 / id1  input  ID_WIDTH each  instruction ID of slot
instruction0 / instruction1  input  INST_WIDTH each  instruction word
branch_taken0 / branch_taken1  input  1 each  fetch predicted taken
branch_taken_address0 / branch_taken_address1  input  ADDR_WIDTH each  predicted target
pop0 / pop1  input  1 each  dispatch consumes head / head+1
free  output  4  DEPTH - count, from registered count
stall  output  1  free == 0
valid0 / valid1  output  1 each  count >= 1 / count >= 2
out_pc0 / out_pc1, out_id0 / out_id1, out_instruction0 / out_instruction1, out_branch_taken0 / out_branch_taken1, out_branch_taken_address0 / out_branch_taken_address1  output  widths as inputs  head / head+1 entry fields; all zero when the matching valid is 0

Behaviour:
- State:
  - circular buffer of DEPTH entries {pc, id, instruction, branch_taken, branch_taken_address};
  - rd_ptr and wr_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH;
  - count, log2(DEPTH)+1 bits.
- Reset (sync, highest priority): rd_ptr = wr_ptr = count = 0. Outputs: free = DEPTH, stall = 0, valid0 = valid1 = 0, all data outputs 0. Entry storage need not be cleared.
- Flush (priority below reset, above everything else): next edge sets rd_ptr = wr_ptr = count = 0. Same-cycle pushes and pops are ignored. The first post-flush push is accepted on the following cycle.
- free, stall, valid0 and valid1 derive only from registered count, so there is no combinational path from push/pop to them.
- Push acceptance, with f = free:
  - acc0 = push0 && f >= 1.
  - acc1 = push1 && f >= (push0 ? 2 : 1).
  - Accepted entries are written in order, slot 0 first, at wr_ptr and wr_ptr+1 (wrapping).
  - When only push1 is accepted, its entry goes to wr_ptr (compaction).
  - Rejected pushes are silently dropped. Fetch must not advance on them: it limits to 1 instruction when free == 1 and holds when stall == 1.
- Pop acceptance:
  - pa0 = pop0 && count >= 1.
  - pa1 = pop1 && pop0 && count >= 2.
  - pop1 without pop0 is ignored.
  - rd_ptr advances by pa0 + pa1.
- Simultaneous push and pop: both legal. Pops consume only entries present at the start of the cycle; an entry written in cycle N is first visible at dispatch in cycle N+1.
- count_next = count + acc0 + acc1 - pa0 - pa1; it never exceeds DEPTH and never goes below 0.
- Full (count == DEPTH): free = 0, stall = 1. A pop in the same cycle does not enable a push that cycle.
- Empty (count == 0): valid0 = valid1 = 0 and pops are ignored.
- Latency: fetch to dispatch visibility is 1 cycle minimum.
- Ordering is strict FIFO; IDs pass through unmodified.

Decomposition:
- Shared defines header: ADDR_WIDTH, INST_WIDTH, INSTRUCTION_ID_WIDTH and NOP_INSTRUCTION, reused as parameter defaults.
- A packed fetch-entry field layout (entry width and bit offsets) also lives in the header, for reuse by the decode stage.
- One sub-module: fetch_queue_ram, a DEPTH x entry-width register file with 2 write ports and 2 combinational read ports. Pointer, count and acceptance logic stays in fetch_queue.

Test Plan:
- Reset, then push0 + push1 of PCs 0x0000 / 0x0001 -> next cycle count 2, free 6, valid0 = valid1 = 1, out_pc0 = 0x0000, out_pc1 = 0x0001.
- Fill: 4 cycles of dual push with no pop -> free 0, stall 1. A further dual push is dropped and count stays 8. Then pop0 + pop1 -> free 2 next cycle.
- free == 1 with push0 + push1 -> only slot 0 written, count 8. Case with only push1 at free == 3 -> entry lands at wr_ptr; out order preserved after pops.
- Wrap: 12 cycles of steady dual push + dual pop with IDs 1..24 -> dispatch sees IDs 1..24 in order, count stays at 2 after warm-up, and pointers wrap with no lost entry.
- Flush with 5 entries, concurrent push0 and pop0 -> next cycle count 0, valid0 = 0, free 8. Pushed entry is absent; the following push appears 1 cycle later.
- Edge cases:
  - pop1 alone with count 3 -> no change.
  - pop0 + pop1 with count 1 -> count 0.
  - Entry with branch_taken = 1, target 0x0040 -> out_branch_taken0 = 1, out_branch_taken_address0 = 0x0040 at head.
